// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory and core-side fetch signals.
// master: the fetch unit. slave: the memory/core environment around it.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at
// a time and buffers returned instructions in a show-ahead prefetch FIFO.
// Redirects flush the buffer; a response still in flight at that moment is
// waited for and thrown away (DISCARD) so it can never reach the core.
// Optional macro IFU_PERF_CNT_EN adds fetch_count / discard_count ports.
module instr_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        discard_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [15:0]      pc;
  logic [15:0]      discard_addr;
  logic [47:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             fifo_valid;
  logic             flush;
  logic             push;
  logic             pop;

  // A redirect in IDLE is meaningless: nothing has been fetched yet.
  assign flush      = bus.redirect && (state != IDLE);
  assign push       = (state == REQ) && bus.imem_ack && !flush;
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid && bus.instr_ready;

  // While discarding, the stale request address is held; pc already holds the target.
  assign bus.imem_req    = (state == REQ) || (state == DISCARD);
  assign bus.imem_addr   = (state == DISCARD) ? discard_addr : pc;
  assign bus.instr_valid = fifo_valid;
  assign bus.instr       = fifo_valid ? fifo_mem[rd_ptr][31:0]  : 32'h0000_0000;
  assign bus.instr_pc    = fifo_valid ? fifo_mem[rd_ptr][47:32] : 16'h0000;

  // Occupancy after this edge: a flush wins, otherwise push and pop cancel.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (flush) begin
          state_next = bus.imem_ack ? REQ : DISCARD;
        end else if (count_next == DEPTH_CNT) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (flush || (count_next < DEPTH_CNT)) begin
          state_next = REQ;
        end
      end
      DISCARD: begin
        if (bus.imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Program counter and the address of a request abandoned by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      if (flush) begin
        pc <= bus.redirect_pc;
      end else if (push) begin
        pc <= pc + 16'd1;
      end
      if ((state == REQ) && flush && !bus.imem_ack) begin
        discard_addr <= pc;
      end
    end
  end

  // FIFO pointers and occupancy; a flush simply restarts both pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // FIFO storage; entries are only read once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pc, bus.imem_rdata};
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic drop;

  assign drop = bus.imem_ack && ((state == DISCARD) || ((state == REQ) && flush));

  // Wrapping performance counters; redirects do not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count   <= 16'h0000;
      discard_count <= 16'h0000;
    end else begin
      if (pop) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (drop) begin
        discard_count <= discard_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A queue-based reference model
// predicts the visible FIFO head, fetch addresses and counters each cycle.
// A second instance with RESET_PC = 16'hFFFE runs against zero-wait memory.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus_wrap ();

`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_count, discard_count, fetch_count_w, discard_count_w;
`endif

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count), .discard_count(discard_count)
`endif
  );

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus_wrap)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count_w), .discard_count(discard_count_w)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a * 16'd7 + 16'h1234, a ^ 16'hBEEF};
  endfunction

  assign bus_wrap.imem_ack    = bus_wrap.imem_req;
  assign bus_wrap.imem_rdata  = mem_word(bus_wrap.imem_addr);
  assign bus_wrap.instr_ready = 1'b1;
  assign bus_wrap.redirect    = 1'b0;
  assign bus_wrap.redirect_pc = 16'h0000;

  logic [47:0] mq[$];
  logic [15:0] m_pc, m_stale_addr, m_fetch_cnt, m_disc_cnt;
  bit          m_stale;
  int          n_vec, n_miss;
  int          mem_lat, wait_left;
  bit          mem_pending;
  logic        s_req, s_valid, s2_req, s2_valid;
  logic [15:0] s_addr, s_pc, s2_addr, s2_pc;
  logic [31:0] s2_instr;
  bit          found;

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_pc        = 16'h0000;
    m_stale     = 1'b0;
    m_stale_addr = 16'h0000;
    m_fetch_cnt = 16'h0000;
    m_disc_cnt  = 16'h0000;
    mem_pending = 1'b0;
    wait_left   = 0;
  endtask

  task automatic doReset();
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    modelReset();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, update the model.
  task automatic applyStimulus(input bit rdy, input bit rdr, input logic [15:0] rpc);
    logic [47:0] head;
    logic [15:0] exp_addr;
    bit          ack;
    bus.instr_ready = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    ack = 1'b0;
    if (bus.imem_req) begin
      if (!mem_pending) begin
        mem_pending = 1'b1;
        wait_left = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
      end
      ack = (wait_left == 0);
    end else begin
      mem_pending = 1'b0;
    end
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? mem_word(bus.imem_addr) : $urandom;
    #1;
    s_req    = bus.imem_req;
    s_addr   = bus.imem_addr;
    s_valid  = bus.instr_valid;
    s_pc     = bus.instr_pc;
    s2_req   = bus_wrap.imem_req;
    s2_addr  = bus_wrap.imem_addr;
    s2_valid = bus_wrap.instr_valid;
    s2_pc    = bus_wrap.instr_pc;
    s2_instr = bus_wrap.instr;
    head = (mq.size() > 0) ? mq[0] : 48'h0;
    checkOutput("instr_valid", 48'(s_valid), 48'(mq.size() != 0));
    checkOutput("instr", 48'(bus.instr), 48'(head[31:0]));
    checkOutput("instr_pc", 48'(s_pc), 48'(head[47:32]));
    exp_addr = m_stale ? m_stale_addr : m_pc;
    if (s_req) checkOutput("imem_addr", 48'(s_addr), 48'(exp_addr));
    if (mq.size() == DEPTH) checkOutput("req_when_full", 48'(s_req), 48'(0));
`ifdef IFU_PERF_CNT_EN
    checkOutput("fetch_count", 48'(fetch_count), 48'(m_fetch_cnt));
    checkOutput("discard_count", 48'(discard_count), 48'(m_disc_cnt));
`endif
    if (rdy && mq.size() > 0) begin
      void'(mq.pop_front());
      m_fetch_cnt++;
    end
    if (ack) begin
      if (m_stale || rdr) begin
        m_disc_cnt++;
        m_stale = 1'b0;
      end else begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc++;
      end
    end
    if (rdr) begin
      mq.delete();
      if (s_req && !ack) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end
      m_pc = rpc;
    end
    @(posedge clk);
    if (ack) mem_pending = 1'b0;
    else if (mem_pending) wait_left--;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    mem_lat = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    modelReset();
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_valid", 48'(bus.instr_valid), 48'(0));
    checkOutput("rst_req", 48'(bus.imem_req), 48'(0));
    checkOutput("rst_addr", 48'(bus.imem_addr), 48'(16'h0000));
    checkOutput("rst_instr", 48'(bus.instr), 48'(0));
    checkOutput("rst_pc", 48'(bus.instr_pc), 48'(0));
    checkOutput("rst_wrap_addr", 48'(bus_wrap.imem_addr), 48'(16'hFFFE));
`ifdef IFU_PERF_CNT_EN
    checkOutput("rst_fetch_count", 48'(fetch_count), 48'(0));
    checkOutput("rst_discard_count", 48'(discard_count_w), 48'(0));
`endif
    rst = 1'b0;

    $display("[TB] streaming from reset, zero-wait memory");
    applyStimulus(1, 0, 0);
    checkOutput("idle_req", 48'(s_req), 48'(0));
    applyStimulus(1, 0, 0);
    checkOutput("first_req", 48'(s_req), 48'(1));
    checkOutput("first_addr", 48'(s_addr), 48'(16'h0000));
    checkOutput("first_valid", 48'(s_valid), 48'(0));
    checkOutput("wrap_addr0", 48'(s2_addr), 48'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput("stream_valid", 48'(s_valid), 48'(1));
      checkOutput("stream_pc", 48'(s_pc), 48'(i));
      checkOutput("stream_addr", 48'(s_addr), 48'(i + 1));
      checkOutput("wrap_addr", 48'(s2_addr), 48'(16'(16'hFFFF + i)));
      checkOutput("wrap_pc", 48'(s2_pc), 48'(16'(16'hFFFE + i)));
      checkOutput("wrap_valid", 48'(s2_valid), 48'(1));
      checkOutput("wrap_instr", 48'(s2_instr), 48'(mem_word(16'(16'hFFFE + i))));
      checkOutput("wrap_req", 48'(s2_req), 48'(1));
    end

    $display("[TB] fill to FULL with instr_ready low");
    doReset();
    mem_lat = 0;
    repeat (5) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("full_req", 48'(s_req), 48'(0));
    checkOutput("full_valid", 48'(s_valid), 48'(1));
    applyStimulus(1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0);
      if (s_req && !found) begin
        found = 1'b1;
        checkOutput("full_rearm_addr", 48'(s_addr), 48'(16'h0004));
      end
    end
    checkOutput("full_rearm_req", 48'(found), 48'(1));

    $display("[TB] redirect while a slow response is outstanding");
    doReset();
    mem_lat = 3;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 16'h0100);
    applyStimulus(1, 0, 0);
    checkOutput("discard_hold_req", 48'(s_req), 48'(1));
    checkOutput("discard_hold_addr", 48'(s_addr), 48'(16'h0000));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1, 0, 0);
      if (s_req && s_addr == 16'h0100) found = 1'b1;
      else checkOutput("discard_no_valid", 48'(s_valid), 48'(0));
    end
    checkOutput("discard_new_addr", 48'(found), 48'(1));
`ifdef IFU_PERF_CNT_EN
    checkOutput("discard_one", 48'(discard_count), 48'(1));
`endif
    repeat (8) applyStimulus(1, 0, 0);

    $display("[TB] redirect together with ack and pop");
    doReset();
    mem_lat = 0;
    repeat (4) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 16'h0200);
    applyStimulus(1, 0, 0);
    checkOutput("redir_valid_low", 48'(s_valid), 48'(0));
    checkOutput("redir_addr", 48'(s_addr), 48'(16'h0200));
`ifdef IFU_PERF_CNT_EN
    checkOutput("redir_fetch_count", 48'(fetch_count), 48'(3));
    checkOutput("redir_discard_count", 48'(discard_count), 48'(1));
`endif
    applyStimulus(1, 0, 0);
    checkOutput("redir_first_valid", 48'(s_valid), 48'(1));
    checkOutput("redir_first_pc", 48'(s_pc), 48'(16'h0200));

    $display("[TB] randomized traffic");
    mem_lat = -1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom));
    end
    mem_lat = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0, 16'($urandom));
    end

    $display("[TB] reset in the middle of a burst");
    applyStimulus(0, 1, 16'h0040);
    for (int i = 0; i < 20 && mq.size() != 3; i++) applyStimulus(0, 0, 0);
    checkOutput("burst_fill", 48'(mq.size() == 3), 48'(1));
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.imem_ack = bus.imem_req;
    bus.imem_rdata = mem_word(bus.imem_addr);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 48'(bus.instr_valid), 48'(0));
    checkOutput("midrst_req", 48'(bus.imem_req), 48'(0));
    checkOutput("midrst_instr", 48'(bus.instr), 48'(0));
    checkOutput("midrst_addr", 48'(bus.imem_addr), 48'(16'h0000));
`ifdef IFU_PERF_CNT_EN
    checkOutput("midrst_fetch_count", 48'(fetch_count), 48'(0));
    checkOutput("midrst_discard_count", 48'(discard_count), 48'(0));
`endif
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    modelReset();
    rst = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("restart_idle_req", 48'(s_req), 48'(0));
    applyStimulus(1, 0, 0);
    checkOutput("restart_req", 48'(s_req), 48'(1));
    checkOutput("restart_addr", 48'(s_addr), 48'(16'h0000));
    repeat (6) applyStimulus(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the 3-stage pipelined core. It owns the program counter, issues word reads to instruction memory, and buffers returned 32-bit instructions in a small prefetch FIFO. The core consumes them through a valid/ready handshake. Taken-branch redirects from the core flush the buffer and restart fetch at a new PC.

## Interface
Parameters:
- FIFO_DEPTH, 4: prefetch entries; power of two, at least 2.
- RESET_PC, 16'h0000: first fetch address after reset.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- imem_req, out, 1: read request to instruction memory.
- imem_addr, out, 16: word address of the current request.
- imem_ack, in, 1: response strobe; may be high in the same cycle as imem_req (zero-wait memory).
- imem_rdata, in, 32: instruction word; valid when imem_ack is high.
- instr, out, 32: head-of-FIFO instruction; 32'h0000_0000 (NOP) whenever instr_valid is low.
- instr_pc, out, 16: PC of instr; 0 when instr_valid is low.
- instr_valid, out, 1: the FIFO is not empty.
- instr_ready, in, 1: the core accepts instr this cycle.
- redirect, in, 1: flush and restart fetch; one-cycle pulse.
- redirect_pc, in, 16: new fetch PC, sampled when redirect is high.

## Operation
- The FSM has four states: IDLE, REQ, FULL and DISCARD. Reset enters IDLE. The first edge after rst is released moves to REQ.
- imem_req = (state == REQ) || (state == DISCARD).
- At most one request is outstanding. imem_addr and imem_req stay stable until imem_ack is sampled high.

REQ state:
- On imem_ack, push {pc, imem_rdata} into the FIFO and set pc <= pc + 1.
- pc is 16 bits and wraps 16'hFFFF to 16'h0000.
- If the FIFO count after the update equals FIFO_DEPTH, go to FULL. Otherwise stay in REQ.

FULL state:
- imem_req is low.
- Return to REQ on the edge after count drops below FIFO_DEPTH.

Redirect (any state except IDLE):
- FIFO count <= 0.
- pc <= redirect_pc.
- If the FSM is in REQ with imem_ack low, go to DISCARD. The old imem_addr is held until imem_ack, the response is dropped, then the FSM returns to REQ at redirect_pc.
- If imem_ack is high in the redirect cycle, the data is dropped and the FSM goes straight to REQ at redirect_pc.
- In FULL, go to REQ.
- In DISCARD, stay in DISCARD with the new target recorded; the latest redirect_pc wins.

Handshake and FIFO rules:
- A pop occurs when instr_valid && instr_ready. The head advances on that edge.
- A pop in the same cycle as redirect completes normally: the core has taken that instruction. The flush still applies.
- A simultaneous push and pop leaves count unchanged.
- Popping an empty FIFO is ignored.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

## Timing
Reset values:
- imem_req 0
- imem_addr RESET_PC
- instr 0, instr_pc 0, instr_valid 0
- FIFO empty, pc RESET_PC
- Perf counters 0

Latency and throughput:
- imem_req rises in the first cycle after the first clk edge following rst release.
- With zero-wait memory, instr_valid rises one cycle after the first imem_ack. The FIFO output is registered and show-ahead.
- Sustained throughput is one instruction per cycle with zero-wait memory and instr_ready held high.
- After redirect, instr_valid is low in the next cycle.
- With zero-wait memory, the instruction at redirect_pc appears 2 cycles after the redirect edge.

Reset behaviour:
- rst asserted mid-operation clears everything immediately. A pending memory response is ignored.

## Configuration
- Macro IFU_PERF_CNT_EN.
- When defined, two extra ports are added:
  - fetch_count, out, 16: counts pops.
  - discard_count, out, 16: counts responses dropped by redirect.
- Both counters are wrapping, reset to 0 and are not cleared by redirect.
- When undefined, the ports and counter logic are absent and behaviour is otherwise identical.

## Test plan
- Reset release with zero-wait memory and instr_ready = 1: imem_addr steps 0, 1, 2, … one per cycle. instr_valid rises 2 cycles after release, and instr_pc follows 0, 1, 2 with matching data.
- instr_ready = 0 with FIFO_DEPTH = 4: after 4 acks the FSM is in FULL and imem_req = 0. One pop re-asserts imem_req on the next cycle, and the next fetch address is 4.
- Memory with 3-cycle ack latency and a redirect to 16'h0100 in the second wait cycle: the old response is dropped (discard_count = 1 when enabled). The next request is at 16'h0100, and no stale instruction is ever valid.
- redirect in the same cycle as imem_ack and a pop: the popped instruction is counted in fetch_count, the acked data is dropped, and the next imem_addr equals redirect_pc.
- Start with RESET_PC = 16'hFFFE: fetch addresses run FFFE, FFFF, 0000, 0001 and instr_pc matches.
- Assert rst mid-burst with the FIFO holding 3 entries: instr_valid, imem_req and the counters drop to 0 immediately, and fetch restarts at RESET_PC.
